bpsk_demodulator: RTL and testbench

//  Receive-side counterpart of the BPSK modulator: coherently demodulates a stream of
//  8-bit signed carrier samples back into data bits. Multiplies each sample by an

---
 rtl/bpsk_demodulator.sv | 215 +++++++++++++++++++++
 tb/tb_bpsk_demodulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// BPSK coherent demodulator: correlates incoming carrier samples against a
// 30-entry sine reference over one symbol, slices the sign of the result into
// a data bit and tracks lock from consecutive strong correlations.
//
// Handshake: sample_valid qualifies sample_in and sym_sync in the same cycle.
// There is no backpressure, so every valid sample is consumed. bit_valid is a
// one-cycle strobe. bit_out and corr_out hold their values between strobes.
`timescale 1ns/1ps
module bpsk_demodulator #(
   parameter int SYM_LEN      = 30,
   parameter int PHASE_OFFSET = 15,
   parameter int ACC_W        = 24,
   parameter int THRESH       = 45000,
   parameter int LOCK_COUNT   = 4
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic signed [7:0]       sample_in,
   input  logic                    sample_valid,
   input  logic                    sym_sync,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic signed [ACC_W-1:0] corr_out,
   output logic                    locked,
   output logic [1:0]              o_dbg_state
);

   localparam int IDX_W  = $clog2(SYM_LEN);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

   // Reference index at symbol start, and the index that follows it
   // (used when a sync sample restarts the symbol).
   localparam logic [IDX_W-1:0] C_IDX_START  = IDX_W'(PHASE_OFFSET);
   localparam logic [IDX_W-1:0] C_IDX_RESYNC = (PHASE_OFFSET == SYM_LEN - 1) ?
                                               '0 : IDX_W'(PHASE_OFFSET + 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(SYM_LEN - 1);
   // The count holds samples already taken. The sample that arrives when the
   // count is SYM_LEN-1 completes the symbol.
   localparam logic [IDX_W-1:0] C_CNT_LAST   = IDX_W'(SYM_LEN - 1);
   localparam logic [IDX_W-1:0] C_CNT_ONE    = IDX_W'(1);
   localparam logic signed [ACC_W-1:0] C_THRESH   = ACC_W'(THRESH);
   localparam logic [GOOD_W-1:0]       C_GOOD_MAX = GOOD_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DUMP  = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [ACC_W-1:0]  w_acc_nxt;
   logic [IDX_W-1:0]         r_idx;
   logic [IDX_W-1:0]         w_idx_nxt;
   logic [IDX_W-1:0]         r_cnt;
   logic [IDX_W-1:0]         w_cnt_nxt;
   logic [GOOD_W-1:0]        r_good;
   logic                     w_done;

   logic [IDX_W-1:0]         w_rd_idx;
   logic [IDX_W-1:0]         w_idx_inc;
   logic signed [7:0]        w_sine;
   logic signed [15:0]       w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_abs;
   logic                     w_good_sym;

   // A sync sample always correlates against the symbol-start phase.
   assign w_rd_idx  = sym_sync ? C_IDX_START : r_idx;
   assign w_idx_inc = (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;

   // Sine reference ROM: one carrier cycle per symbol. The second half is the
   // negated first half.
   always_comb begin
      w_sine = 8'sd0;
      case (w_rd_idx)
         5'd0:  w_sine = 8'sd0;
         5'd1:  w_sine = 8'sd16;
         5'd2:  w_sine = 8'sd31;
         5'd3:  w_sine = 8'sd45;
         5'd4:  w_sine = 8'sd58;
         5'd5:  w_sine = 8'sd67;
         5'd6:  w_sine = 8'sd74;
         5'd7:  w_sine = 8'sd77;
         5'd8:  w_sine = 8'sd77;
         5'd9:  w_sine = 8'sd74;
         5'd10: w_sine = 8'sd67;
         5'd11: w_sine = 8'sd58;
         5'd12: w_sine = 8'sd45;
         5'd13: w_sine = 8'sd31;
         5'd14: w_sine = 8'sd16;
         5'd15: w_sine = 8'sd0;
         5'd16: w_sine = -8'sd16;
         5'd17: w_sine = -8'sd31;
         5'd18: w_sine = -8'sd45;
         5'd19: w_sine = -8'sd58;
         5'd20: w_sine = -8'sd67;
         5'd21: w_sine = -8'sd74;
         5'd22: w_sine = -8'sd77;
         5'd23: w_sine = -8'sd77;
         5'd24: w_sine = -8'sd74;
         5'd25: w_sine = -8'sd67;
         5'd26: w_sine = -8'sd58;
         5'd27: w_sine = -8'sd45;
         5'd28: w_sine = -8'sd31;
         5'd29: w_sine = -8'sd16;
         default: w_sine = 8'sd0;
      endcase
   end

   // The 16-bit signed product is sign-extended into the accumulator. With
   // |acc| <= 30*128*77 the accumulator cannot overflow.
   assign w_prod     = sample_in * w_sine;
   assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
   assign w_sum      = r_acc + w_prod_ext;
   assign w_abs      = w_sum[ACC_W-1] ? -w_sum : w_sum;
   assign w_good_sym = (w_abs >= C_THRESH);

   // Next-state and datapath decisions. DUMP behaves like ACCUM at a fresh
   // symbol start, so a sample arriving during DUMP is taken straight away.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sample_valid && sym_sync) begin
               w_acc_nxt   = w_prod_ext;
               w_idx_nxt   = C_IDX_RESYNC;
               w_cnt_nxt   = C_CNT_ONE;
               w_state_nxt = S_ACCUM;
            end
         end
         S_ACCUM, S_DUMP: begin
            w_state_nxt = S_ACCUM;
            if (sample_valid) begin
               if (sym_sync) begin
                  // Restart: discard the partial symbol.
                  w_acc_nxt = w_prod_ext;
                  w_idx_nxt = C_IDX_RESYNC;
                  w_cnt_nxt = C_CNT_ONE;
               end else if (r_cnt == C_CNT_LAST) begin
                  w_done      = 1'b1;
                  w_acc_nxt   = '0;
                  w_idx_nxt   = C_IDX_START;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_DUMP;
               end else begin
                  w_acc_nxt = w_sum;
                  w_idx_nxt = w_idx_inc;
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Correlator registers: accumulator, reference index and sample count.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_acc <= '0;
         r_idx <= C_IDX_START;
         r_cnt <= '0;
      end else begin
         r_acc <= w_acc_nxt;
         r_idx <= w_idx_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   // Symbol results and lock tracking. These update only when a symbol completes.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         corr_out  <= '0;
         r_good    <= '0;
         locked    <= 1'b0;
      end else begin
         bit_valid <= w_done;
         if (w_done) begin
            corr_out <= w_sum;
            bit_out  <= ~w_sum[ACC_W-1];
            if (w_good_sym) begin
               if (r_good != C_GOOD_MAX) begin
                  r_good <= r_good + 1'b1;
               end
               locked <= (r_good >= C_GOOD_MAX - 1'b1);
            end else begin
               r_good <= '0;
               locked <= 1'b0;
            end
         end
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Testbench for bpsk_demodulator. A reference model collects the accepted
// samples of each symbol, correlates them against the sine table with plain
// integer arithmetic, and predicts the strobe, bit, correlation and lock state.
`timescale 1ns/1ps
module tb_bpsk_demodulator;

   localparam int SYM_LEN = 30;
   localparam int THRESH  = 45000;

   // ---------------- clock / reset ----------------
   logic              Clk = 1'b0;
   logic              Rst_n = 1'b0;
   logic signed [7:0] sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              sym_sync = 1'b0;
   logic              bit_out;
   logic              bit_valid;
   logic signed [23:0] corr_out;
   logic              locked;
   logic [1:0]        dbg_state;

   always #5 Clk = ~Clk;

   bpsk_demodulator dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sym_sync     (sym_sync),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .corr_out     (corr_out),
      .locked       (locked),
      .o_dbg_state  (dbg_state)
   );

   // ---------------- scoreboard / model state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [23:0] exp_q[$];
   int          sym_q[$];
   bit          active = 0;
   int          good = 0;
   bit          exp_locked = 0;
   bit          exp_bit = 0;
   int          exp_corr_hold = 0;
   int          cyc = 0;
   int          strobe_cnt = 0;
   int          last_strobe_cyc = -1;
   int          last_gap = 0;
   int          last_corr = 0;
   bit          last_bit = 0;
   bit          last_locked = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int ref_sine(input int i);
      int t[15] = '{0, 16, 31, 45, 58, 67, 74, 77, 77, 74, 67, 58, 45, 31, 16};
      return (i < 15) ? t[i] : -t[i - 15];
   endfunction

   function automatic int clamp8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   // Drive one cycle, advance the model, and compare every output.
   task automatic step(input bit v, input bit sy, input int s);
      int corr;
      int mag;
      bit done;
      logic [23:0] e;
      sample_valid = v;
      sym_sync     = sy;
      sample_in    = 8'(s);
      @(posedge Clk);
      #1;
      cyc++;
      done = 0;
      corr = 0;
      if (v) begin
         if (sy) begin
            active = 1;
            sym_q.delete();
         end
         if (active) sym_q.push_back(int'(sample_in));
         if (active && sym_q.size() == SYM_LEN) begin
            foreach (sym_q[k]) corr += sym_q[k] * ref_sine((k + 15) % SYM_LEN);
            sym_q.delete();
            done = 1;
            mag = (corr < 0) ? -corr : corr;
            if (mag >= THRESH) good = (good < 4) ? good + 1 : 4;
            else good = 0;
            exp_locked    = (good >= 4);
            exp_bit       = (corr >= 0);
            exp_corr_hold = corr;
            exp_q.push_back(corr[23:0]);
         end
      end
      check("bit_valid", int'(bit_valid), int'(done));
      if (bit_valid) begin
         strobe_cnt++;
         if (last_strobe_cyc >= 0) last_gap = cyc - last_strobe_cyc;
         last_strobe_cyc = cyc;
         last_corr   = int'(corr_out);
         last_bit    = bit_out;
         last_locked = locked;
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("corr_out", int'(corr_out), int'($signed(e)));
         end
      end
      check("corr_hold", int'(corr_out), exp_corr_hold);
      check("bit_out", int'(bit_out), int'(exp_bit));
      check("locked", int'(locked), int'(exp_locked));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         Rst_n        = 1'b0;
         sample_valid = 1'($urandom_range(0, 1));
         sym_sync     = 1'($urandom_range(0, 1));
         sample_in    = 8'($urandom_range(0, 255));
         @(posedge Clk);
         #1;
         cyc++;
         check("rst_bit_valid", int'(bit_valid), 0);
         check("rst_bit_out", int'(bit_out), 0);
         check("rst_corr", int'(corr_out), 0);
         check("rst_locked", int'(locked), 0);
      end
      Rst_n = 1'b1;
      sample_valid = 1'b0;
      sym_sync = 1'b0;
      active = 0;
      sym_q.delete();
      exp_q.delete();
      good = 0;
      exp_locked = 0;
      exp_bit = 0;
      exp_corr_hold = 0;
      last_strobe_cyc = -1;
   endtask

   // mode 0: full sine scaled by pol; mode 1: first half only (|corr|=45000);
   // mode 2: first half with one sample nudged (|corr|=44984).
   task automatic send_sym(input int pol, input bit sync, input int mode);
      int v;
      for (int k = 0; k < SYM_LEN; k++) begin
         v = pol * ref_sine((k + 15) % SYM_LEN);
         if (mode != 0 && k >= 15) v = 0;
         if (mode == 2 && k == 1) v = pol * -15;
         step(1, sync && (k == 0), v);
      end
   endtask

   // ---------------- stimulus ----------------
   int s0;
   int t0;
   int c30;
   int pol;
   int amp;
   int ph;
   int v;
   bit sy;
   bit vv;

   initial begin
      int pat[5] = '{1, -1, 1, 1, -1};
      int bits[5] = '{1, 0, 1, 1, 0};

      do_reset(3);

      // Ideal carrier, one symbol.
      s0 = strobe_cnt;
      send_sym(1, 1, 0);
      step(0, 0, 0);
      check("t1_strobes", strobe_cnt - s0, 1);
      check("t1_corr", last_corr, 90000);
      check("t1_bit", int'(last_bit), 1);

      // Back-to-back bit stream 1,0,1,1,0.
      do_reset(2);
      s0 = strobe_cnt;
      for (int i = 0; i < 5; i++) begin
         send_sym(pat[i], i == 0, 0);
         check("t2_bit", int'(last_bit), bits[i]);
         check("t2_corr", last_corr, pat[i] * 90000);
         if (i > 0) check("t2_gap", last_gap, 30);
      end
      check("t2_strobes", strobe_cnt - s0, 5);

      // Lock with four good symbols, then lose it on an all-zero symbol.
      do_reset(2);
      for (int i = 0; i < 4; i++) begin
         send_sym((i % 2 == 0) ? 1 : -1, i == 0, 0);
         check("t3_locked", int'(last_locked), (i == 3) ? 1 : 0);
      end
      send_sym(0, 0, 0);
      check("t3_unlock", int'(last_locked), 0);
      check("t3_zero_corr", last_corr, 0);
      check("t3_zero_bit", int'(last_bit), 1);

      // Threshold boundary: exactly THRESH counts as good, just below does not.
      do_reset(2);
      for (int i = 0; i < 4; i++) send_sym(1, i == 0, 1);
      check("thr_corr", last_corr, 45000);
      check("thr_locked", int'(last_locked), 1);
      send_sym(-1, 0, 2);
      check("thr_below_corr", last_corr, -44984);
      check("thr_below_locked", int'(last_locked), 0);

      // sample_valid toggling through a symbol.
      do_reset(2);
      s0 = strobe_cnt;
      t0 = cyc;
      for (int k = 0; k < SYM_LEN; k++) begin
         step(1, k == 0, ref_sine((k + 15) % SYM_LEN));
         if (k < SYM_LEN - 1) step(0, 0, int'($urandom_range(0, 255)) - 128);
      end
      c30 = cyc;
      step(0, 0, 0);
      check("t4_strobes", strobe_cnt - s0, 1);
      check("t4_latency", last_strobe_cyc - t0, 59);
      check("t4_strobe_cyc", last_strobe_cyc, c30);
      check("t4_corr", last_corr, 90000);

      // Resync at sample 12 discards the partial symbol.
      do_reset(2);
      s0 = strobe_cnt;
      for (int k = 0; k < 12; k++) step(1, k == 0, ref_sine((k + 15) % SYM_LEN));
      t0 = cyc;
      send_sym(-1, 1, 0);
      check("t5_strobes", strobe_cnt - s0, 1);
      check("t5_latency", last_strobe_cyc - t0, 30);
      check("t5_corr", last_corr, -90000);

      // Reset mid-symbol, then unsynchronised samples stay ignored.
      do_reset(2);
      s0 = strobe_cnt;
      for (int k = 0; k < 20; k++) step(1, k == 0, ref_sine((k + 15) % SYM_LEN));
      do_reset(1);
      for (int k = 0; k < 40; k++) step(1, 0, ref_sine((k + 15) % SYM_LEN));
      check("t6_strobes", strobe_cnt - s0, 0);

      // Randomised stream: varying polarity, amplitude, noise, gaps and resyncs.
      do_reset(2);
      pol = 1;
      amp = 4;
      ph = 0;
      for (int n = 0; n < 2000; n++) begin
         if (n == 1000) begin
            do_reset(1);
            ph = 0;
         end
         if ($urandom_range(0, 29) == 0) begin
            pol = ($urandom_range(0, 1) == 1) ? 1 : -1;
            amp = int'($urandom_range(0, 6));
         end
         sy = (n == 0) || (n == 1001) || ($urandom_range(0, 79) == 0);
         vv = sy || ($urandom_range(0, 3) != 0);
         if (vv && sy) ph = 0;
         v = clamp8(pol * amp * ref_sine((ph + 15) % SYM_LEN) / 4
                    + int'($urandom_range(0, 16)) - 8);
         step(vv, sy, v);
         if (vv) ph = (ph + 1) % SYM_LEN;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
